fetch_unit: RTL and testbench

- Instruction fetch stage that feeds the main decoder; the decoder consumes Instr[27:26] (Op) and Instr[25:20] (Funct).
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake with variable latency.
- Buffers returned words in a small FIFO, so decode stalls do not stall memory.
- Handles branch redirects with flush and discard of in-flight data, and presents each instruction with its PC and PC+8 (ARM read-PC semantics).

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch FSM with a single-outstanding req/ack memory port and a small instruction FIFO
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc8,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   addr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic          push;
    logic          pop;

    // redirect squashes both the in-flight word and any pop in the same cycle
    assign push     = (state == WAIT) && imem_ack && !redirect;
    assign pop      = instr_valid && instr_ready && !redirect;
    assign count_nx = count + CW'(push) - CW'(pop);

    assign imem_req    = (state != IDLE);
    assign imem_addr   = addr;
    assign instr_valid = (count != '0);
    assign instr       = buf_instr[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];
    assign instr_pc8   = instr_pc + 32'd8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr     <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]    <= addr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (redirect) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_pc & ~32'd3;
            end else begin
                count <= count_nx;
                if (push)
                    fetch_pc <= fetch_pc + 32'd4;
            end
            // space check includes the outstanding request, so a push never overflows
            if (state == IDLE) begin
                if (!redirect && count < FULL) begin
                    state <= WAIT;
                    addr  <= fetch_pc;
                end
            end else if (state == WAIT) begin
                if (push && count_nx < FULL)
                    addr <= fetch_pc + 32'd4;
                else if (imem_ack)
                    state <= IDLE;
                else if (redirect)
                    state <= DROP;
            end else if (imem_ack || state != DROP) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized checks of fetch_unit against a program-order stream model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc8;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc8;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat_fix = 0;
    int          wait_cnt = 0;
    int          accepted = 0;
    logic [31:0] exp_pc = '0;
    logic        have_prev = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_pc8(instr_pc8),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // wrap-around instance: zero-latency memory, decoder always ready
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(mem_word(w_addr)),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc), .instr_pc8(w_pc8),
        .instr_ready(1'b1), .redirect(1'b0), .redirect_pc(32'd0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int pick_lat();
        return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        wait_cnt = pick_lat();
        have_prev = 1'b0;
        exp_pc = 32'h0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_pc8", instr_pc8, 32'h8);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one cycle: memory responds, decoder inputs driven, accepted words checked against program order
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        if (have_prev && prev_req && !prev_ack) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, prev_addr);
        end
        check("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (imem_req && wait_cnt == 0) begin
            imem_ack = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wait_cnt = pick_lat();
        end else begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (imem_req) wait_cnt--;
        end
        instr_ready = rdy;
        redirect = rd;
        redirect_pc = rpc;
        if (rd) begin
            exp_pc = rpc & ~32'd3;
        end else if (instr_valid && rdy) begin
            check("stream_pc", instr_pc, exp_pc);
            check("stream_instr", instr, mem_word(exp_pc));
            check("stream_pc8", instr_pc8, exp_pc + 32'd8);
            exp_pc += 32'd4;
            accepted++;
        end
        prev_req = imem_req;
        prev_ack = imem_ack;
        prev_addr = imem_addr;
        have_prev = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !instr_valid; i++) cycle(1'b0, 1'b0, 32'd0);
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        // zero-latency stream, plus wrap-around instance
        lat_fix = 0;
        do_reset();
        cycle(1'b1, 1'b0, 32'd0);
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        check("t1_valid0", 32'(instr_valid), 32'd0);
        check("t6_waddr", w_addr, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'd0);
        check("t1_valid1", 32'(instr_valid), 32'd1);
        check("t6_wpc0", w_pc, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'd0);
        check("t1_pc1", instr_pc, 32'h4);
        check("t6_wpc1", w_pc, 32'hFFFF_FFFC);
        check("t6_wpc8", w_pc8, 32'h0000_0004);
        cycle(1'b1, 1'b0, 32'd0);
        check("t1_pc2", instr_pc, 32'h8);
        check("t6_wpc2", w_pc, 32'h0000_0000);
        check("t6_winstr", w_instr, mem_word(32'h0));
        cycle(1'b1, 1'b0, 32'd0);
        check("t1_pc3", instr_pc, 32'hC);
        check("t1_pc8", instr_pc8, 32'h14);

        // decoder stalled: buffer fills to DEPTH then fetch stops
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0);
        check("t2_req_low", 32'(imem_req), 32'd0);
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_head", instr_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 6 && !imem_req; i++) cycle(1'b1, 1'b0, 32'd0);
        check("t2_resume_req", 32'(imem_req), 32'd1);
        check("t2_resume_addr", imem_addr, 32'h8);

        // slow memory: request held stable until ack
        lat_fix = 3;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            check("t3_req", 32'(imem_req), 32'd1);
            check("t3_addr", imem_addr, 32'h0);
            check("t3_novalid", 32'(instr_valid), 32'd0);
        end
        cycle(1'b1, 1'b0, 32'd0);
        check("t3_ackcyc_valid", 32'(instr_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_pc", instr_pc, 32'h0);

        // redirect during WAIT: stale word dropped
        lat_fix = 2;
        do_reset();
        cycle(1'b0, 1'b1, 32'h0000_0103);
        cycle(1'b0, 1'b0, 32'd0);
        check("t4_drop_req", 32'(imem_req), 32'd1);
        check("t4_drop_addr", imem_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check("t4_new_req", 32'(imem_req), 32'd1);
        check("t4_new_addr", imem_addr, 32'h100);
        wait_valid("t4_valid");
        check("t4_pc", instr_pc, 32'h100);
        check("t4_instr", instr, mem_word(32'h100));

        // redirect coinciding with ack and pop
        lat_fix = 1;
        do_reset();
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check("t5_pre_valid", 32'(instr_valid), 32'd1);
        check("t5_pre_addr", imem_addr, 32'h4);
        cycle(1'b1, 1'b1, 32'h0000_0040);
        cycle(1'b0, 1'b0, 32'd0);
        check("t5_flush_valid", 32'(instr_valid), 32'd0);
        check("t5_flush_req", 32'(imem_req), 32'd0);
        wait_valid("t5_valid");
        check("t5_pc", instr_pc, 32'h40);

        // async reset in the middle of a transaction
        lat_fix = 3;
        do_reset();
        cycle(1'b0, 1'b0, 32'd0);
        check("t6_mid_req", 32'(imem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_req", 32'(imem_req), 32'd0);
        check("t6_async_wreq", 32'(w_req), 32'd0);
        check("t6_async_waddr", w_addr, 32'hFFFF_FFF8);
        do_reset();
        cycle(1'b0, 1'b0, 32'd0);
        check("t6_restart_req", 32'(imem_req), 32'd1);
        check("t6_restart_addr", imem_addr, 32'h0);

        // randomized latency, stalls and redirects
        lat_fix = -1;
        do_reset();
        accepted = 0;
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom);
        check("rand_progress", 32'(accepted >= 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
